// File: rtl/tmac_uni_param.sv
// Unipolar temporal-coded stochastic MAC: N_CH channels, one 2^BW-cycle frame per result.
// Define TMAC_SCALED_EN for scaled output coding (mean); default build saturates the sum.
module tmac_uni_param #(
    parameter int N_CH = 16,
    parameter int BW   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N_CH-1:0][BW-1:0]      iA,
    input  logic [N_CH-1:0][BW-1:0]      iB,
    output logic                         busy,
    output logic                         done,
    output logic [BW+$clog2(N_CH)-1:0]   oSum,
    output logic [BW-1:0]                oRes,
    output logic                         oC
);

    localparam int LG_CH = $clog2(N_CH);
    localparam int SUM_W = BW + LG_CH;
    localparam int CNT_W = BW + 1;
    localparam int N_ST  = (LG_CH + 1) / 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [BW-1:0] T_MAX = '1;
    localparam logic [BW-1:0] T_DR  = BW'(N_ST - 1);

    logic [2:0]                state;
    logic [2:0]                state_n;
    logic [BW-1:0]             t;
    logic [BW-1:0]             tc;
    logic [BW-1:0]             rng_a;
    logic [BW-1:0]             rng_c;
    logic [N_CH-1:0][BW-1:0]   a_r;
    logic [N_CH-1:0][BW-1:0]   b_r;
    logic [CNT_W-1:0]          cnt [N_CH];
    logic [N_CH-1:0]           mul;
    logic [SUM_W-1:0]          tree_out;
    logic [BW-1:0]             res_code;
    logic                      res_valid;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = S_LOAD;
            S_LOAD:  state_n = S_RUN;
            S_RUN:   if (t == T_MAX) state_n = S_DRAIN;
            S_DRAIN: if (t == T_DR) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // t doubles as the drain-cycle counter once the frame is over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= '0;
        end else if (state == S_RUN || state == S_DRAIN) begin
            t <= (state_n != state) ? '0 : t + 1'b1;
        end else begin
            t <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc <= '0;
        end else begin
            tc <= tc + 1'b1;
        end
    end

    // van der Corput sequences for the rate-coded operand and the output stream
    always_comb begin
        rng_a = '0;
        rng_c = '0;
        for (int j = 0; j < BW; j++) begin
            rng_a[j] = t[BW-1-j];
            rng_c[j] = tc[BW-1-j];
        end
    end

    always_comb begin
        mul = '0;
        for (int i = 0; i < N_CH; i++) begin
            mul[i] = (a_r[i] > rng_a) && (t < b_r[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else if (state == S_IDLE && start) begin
            a_r <= iA;
            b_r <= iB;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else if (state == S_RUN) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt[i] + CNT_W'(mul[i]);
            end
        end
    end

    // 4:1 reduction levels; last level is combinational into the oSum register
    for (genvar k = 0; k < N_ST; k++) begin : g_lvl
        localparam int NIN  = N_CH >> (2 * k);
        localparam int NOUT = (NIN >= 4) ? NIN / 4 : 1;
        localparam int FAN  = NIN / NOUT;

        logic [SUM_W-1:0] din [NIN];
        logic [SUM_W-1:0] sum [NOUT];
        logic [SUM_W-1:0] q   [NOUT];

        if (k == 0) begin : g_in
            for (genvar i = 0; i < NIN; i++) begin : g_i
                assign din[i] = SUM_W'(cnt[i]);
            end
        end else begin : g_in
            for (genvar i = 0; i < NIN; i++) begin : g_i
                assign din[i] = g_lvl[k-1].q[i];
            end
        end

        always_comb begin
            for (int o = 0; o < NOUT; o++) begin
                logic [SUM_W-1:0] acc;
                acc = '0;
                for (int f = 0; f < FAN; f++) begin
                    acc = acc + din[o*FAN+f];
                end
                sum[o] = acc;
            end
        end

        if (k < N_ST - 1) begin : g_ff
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int o = 0; o < NOUT; o++) q[o] <= '0;
                end else begin
                    for (int o = 0; o < NOUT; o++) q[o] <= sum[o];
                end
            end
        end else begin : g_co
            for (genvar o = 0; o < NOUT; o++) begin : g_o
                assign q[o] = sum[o];
            end
        end
    end

    assign tree_out = g_lvl[N_ST-1].q[0];

`ifdef TMAC_SCALED_EN
    assign res_code = tree_out[SUM_W-1:LG_CH];
`else
    assign res_code = (|tree_out[SUM_W-1:BW]) ? '1 : tree_out[BW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oSum      <= '0;
            oRes      <= '0;
            res_valid <= 1'b0;
        end else if (state == S_DRAIN && state_n == S_DONE) begin
            oSum      <= tree_out;
            oRes      <= res_code;
            res_valid <= 1'b1;
        end
    end

    assign busy = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign oC   = res_valid && (oRes > rng_c);

endmodule

// File: tb/tb_tmac_uni_param.sv
// Scoreboard bench for tmac_uni_param: random and directed frames vs a frame-level model.
// Expected results are queued at start; a negedge monitor pops on every done pulse.
module tb_tmac_uni_param;

    localparam int N_CH  = 16;
    localparam int BW    = 8;
    localparam int LG    = $clog2(N_CH);
    localparam int SUM_W = BW + LG;
    localparam int FRAME = 1 << BW;
    localparam int MAXV  = FRAME - 1;
    localparam int DRAIN = (LG + 1) / 2;
    localparam int LAT   = 1 + FRAME + DRAIN + 1;
    localparam int GAP   = FRAME + DRAIN + 3;

    typedef logic [N_CH-1:0][BW-1:0] ops_t;
    typedef struct {
        int sum;
        int res;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    ops_t             iA;
    ops_t             iB;
    logic             busy;
    logic             done;
    logic [SUM_W-1:0] oSum;
    logic [BW-1:0]    oRes;
    logic             oC;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q[$];

    tmac_uni_param #(.N_CH(N_CH), .BW(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .iA    (iA),
        .iB    (iB),
        .busy  (busy),
        .done  (done),
        .oSum  (oSum),
        .oRes  (oRes),
        .oC    (oC)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference: one pass over the frame per channel, straight from the coding rules
    function automatic int rev(int x);
        int r = 0;
        for (int j = 0; j < BW; j++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic int ch_cnt(int a, int b);
        int c = 0;
        for (int t = 0; t < FRAME; t++) begin
            if (a > rev(t) && t < b) c++;
        end
        return c;
    endfunction

    function automatic void model(input ops_t a, input ops_t b,
                                  output int s, output int r);
        s = 0;
        for (int i = 0; i < N_CH; i++) s += ch_cnt(int'(a[i]), int'(b[i]));
`ifdef TMAC_SCALED_EN
        r = s / N_CH;
`else
        r = (s > MAXV) ? MAXV : s;
`endif
    endfunction

    function automatic ops_t fill(int v);
        ops_t x;
        for (int i = 0; i < N_CH; i++) x[i] = BW'(v);
        return x;
    endfunction

    function automatic ops_t rnd(int lo, int hi);
        ops_t x;
        for (int i = 0; i < N_CH; i++) x[i] = BW'($urandom_range(lo, hi));
        return x;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("sb_oSum", oSum, e.sum);
                chk("sb_oRes", oRes, e.res);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy=%0d expected 0", busy);
        end
    endtask

    task automatic push_exp(input ops_t a, input ops_t b, output int r);
        exp_t e;
        int   s;
        model(a, b, s, r);
        e.sum = s;
        e.res = r;
        q.push_back(e);
    endtask

    task automatic run_frame(input ops_t a, input ops_t b, input bit poke, output int r);
        int n;
        int sc;
        wait_idle();
        push_exp(a, b, r);
        iA    = a;
        iB    = b;
        start = 1'b1;
        sc    = cyc;
        @(negedge clk);
        start = 1'b0;
        iA    = rnd(0, MAXV);
        iB    = rnd(0, MAXV);
        n = 0;
        while (!done && n < 2000) begin
            start = poke && (n % 37 == 5);
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected within %0d cycles", n);
        end else begin
            chk("latency", cyc - sc, LAT);
        end
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("start_in_done_ignored", busy, 0);
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic oc_window(input int exp);
        int c = 0;
        repeat (FRAME) begin
            @(negedge clk);
            c += int'(oC);
        end
        chk("oC_ones", c, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ops_t a;
        ops_t b;
        int   r;
        int   nd;
        int   d[3];

        rst_n = 1'b0;
        start = 1'b0;
        iA    = '0;
        iB    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_oSum", oSum, 0);
        chk("rst_oRes", oRes, 0);
        chk("rst_oC", oC, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(fill(128), fill(64), 0, r);
        chk("c1_oSum", oSum, 512);
`ifdef TMAC_SCALED_EN
        chk("c1_oRes", oRes, 32);
`else
        chk("c1_oRes", oRes, 255);
`endif
        oc_window(r);

        run_frame(fill(255), fill(255), 0, r);
        chk("c2_oSum", oSum, 4080);
        chk("c2_oRes", oRes, 255);
        oc_window(255);

        run_frame(fill(0), rnd(0, MAXV), 0, r);
        chk("a0_oSum", oSum, 0);
        oc_window(0);
        run_frame(rnd(0, MAXV), fill(0), 0, r);
        chk("b0_oSum", oSum, 0);

        a = fill(0);
        b = fill(0);
        a[3] = 8'd200;
        b[3] = 8'd128;
        run_frame(a, b, 0, r);
        chk("ch3_oSum", oSum, 100);
`ifdef TMAC_SCALED_EN
        chk("ch3_oRes", oRes, 6);
`else
        chk("ch3_oRes", oRes, 100);
`endif
        oc_window(r);

        run_frame(rnd(0, MAXV), rnd(0, MAXV), 1, r);
        nd = 0;
        repeat (300) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("no_extra_done", nd, 0);

        a = rnd(0, MAXV);
        b = rnd(0, MAXV);
        wait_idle();
        repeat (3) push_exp(a, b, r);
        iA    = a;
        iB    = b;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nd = 0;
            do begin
                @(negedge clk);
                nd++;
            end while (!done && nd < 2000);
            d[k] = cyc;
        end
        start = 1'b0;
        chk("b2b_gap1", d[1] - d[0], GAP);
        chk("b2b_gap2", d[2] - d[1], GAP);

        a = rnd(64, MAXV);
        b = rnd(64, MAXV);
        wait_idle();
        iA    = a;
        iB    = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (101) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_oSum", oSum, 0);
        chk("abort_oRes", oRes, 0);
        chk("abort_oC", oC, 0);
        @(negedge clk);
        rst_n = 1'b1;
        oc_window(0);
        run_frame(a, b, 0, r);
        chk("rerun_oRes", oRes, r);

        for (int k = 0; k < 5; k++) begin
            a = rnd(0, MAXV);
            b = rnd(0, MAXV);
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 7) == 0) a[i] = '0;
                if ($urandom_range(0, 7) == 0) b[i] = '0;
            end
            run_frame(a, b, 0, r);
        end
        oc_window(r);

        @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
